counter_sequencer: RTL
======================

Name: counter_sequencer

Overview:
Controller for the board's 24-bit demo counter datapath. Accepts commands over a valid/ready interface, generates prescaled increment strobes, and clears the counter. It compares the counter value against a programmable compare value and supports one-shot and periodic runs. It sits between the IO/command logic and the counter register; the counter itself stays a separate datapath block.

Parameters:
CTR_W, 24, counter datapath width
PRESCALE_W, 16, prescaler limit width
PRESCALE_DEFAULT, 1000, prescaler limit after reset

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when valid&ready
cmd_op  input  3  opcode
cmd_data  input  CTR_W  operand
ctr_q  input  CTR_W  current counter value from datapath
ctr_inc  output  1  one-cycle increment strobe to datapath
ctr_clr  output  1  one-cycle synchronous clear to datapath
match_pulse  output  1  one-cycle compare-reached pulse
state_o  output  2  current state: 0 IDLE, 1 RUN, 2 PAUSED, 3 DONE
busy  output  1  state_o is RUN or PAUSED

Behaviour:
- Reset (async, active-high), all registered:
  - state IDLE; ctr_inc, ctr_clr and match_pulse 0; cmd_ready 1.
  - prescale_lim=PRESCALE_DEFAULT; compare=0; prescaler count 0; mode one-shot.
- Opcodes:
  - 0 NOP.
  - 1 SET_PRESCALE: lim=cmd_data[PRESCALE_W-1:0].
  - 2 SET_COMPARE: compare=cmd_data.
  - 3 START_ONESHOT.
  - 4 START_PERIODIC.
  - 5 PAUSE.
  - 6 RESUME.
  - 7 STOP.
- Opcodes illegal in the current state are accepted and ignored:
  - PAUSE outside RUN.
  - RESUME outside PAUSED.
  - STOP in IDLE.
- START in any state:
  - Next cycle: ctr_clr=1, prescaler count=0, mode latched, state RUN.
  - cmd_ready=0 during that ctr_clr cycle only.
- Prescaler:
  - Counts only in RUN.
  - When count==lim: tick fires, count wraps to 0.
  - Tick period is lim+1 cycles; lim=0 gives a tick every cycle.
  - SET_PRESCALE while RUN with count>=new lim: the tick fires on the next cycle.
- Tick in RUN, next=ctr_q+1 mod 2^CTR_W:
  - one-shot, next!=compare: ctr_inc=1.
  - one-shot, next==compare: ctr_inc=1 and match_pulse=1 in the same cycle; state DONE next cycle.
  - periodic, next!=compare: ctr_inc=1.
  - periodic, next==compare: ctr_clr=1 (not ctr_inc) and match_pulse=1; stays RUN. The counter sequence is 0..compare-1.
  - compare=0 means the full 2^CTR_W range; the modulo arithmetic gives this naturally.
- Strobes are outputs registered from the tick cycle, so they appear one cycle after count==lim. ctr_inc and ctr_clr are never both 1.
- PAUSE: state PAUSED; prescaler count held.
- RESUME: state RUN; counting continues from the held count.
- STOP: ctr_clr=1 next cycle; state IDLE; prescaler count=0.
- DONE: the counter holds at compare; only START or STOP leaves DONE (STOP clears the counter).
- Command accepted in the same cycle a tick fires:
  - PAUSE and STOP suppress that tick: no inc, clr or match.
  - SET_COMPARE and SET_PRESCALE take effect after that tick, which uses the old values.
- ctr_q is trusted; the controller keeps no shadow count.
- rst asserted mid-run returns everything to reset values immediately (asynchronously), including strobes.

Decomposition:
- Shared package counter_seq_pkg holds:
  - opcode localparams OP_NOP..OP_STOP (3 bits);
  - state encodings ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE (2 bits);
  - mode encoding.
- One sub-module, counter_prescaler:
  - inputs clk, rst, run, lim[PRESCALE_W-1:0];
  - output tick (combinational on count==lim&&run);
  - holds count when run=0 and has a clear input.
- The FSM, compare logic and command decode stay in counter_sequencer.

Test Plan:
- Reset then idle 20 cycles -> state_o=0, ctr_inc/ctr_clr/match_pulse never 1, cmd_ready=1.
- SET_PRESCALE 3, SET_COMPARE 5, START_ONESHOT (bench counter model) -> one ctr_clr, then exactly 5 ctr_inc spaced 4 cycles apart; match_pulse with the 5th; state_o=3; ctr_q holds 5.
- SET_PRESCALE 0, SET_COMPARE 4, START_PERIODIC, run 12 cycles -> ctr_q sequence 0,1,2,3,0,1,2,3,...; match_pulse every 4th cycle coincident with ctr_clr.
- Periodic run with lim=9: PAUSE at ctr_q=2, wait 50 cycles, RESUME -> no strobes while paused; next ctr_inc arrives after the remaining prescale cycles, not after a full 10.
- PAUSE issued in the exact cycle a tick fires -> no ctr_inc that cycle; STOP in the DONE state -> ctr_clr=1 once, state_o=0.
- Assert rst for 1 cycle mid-run, asynchronous to clk -> outputs 0 immediately; after release state_o=0, PRESCALE_DEFAULT restored (a new START gives a tick period of 1001 cycles).

Source files
------------

// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - shared opcodes, state and mode encodings for the counter sequencer
package counter_seq_pkg;

  localparam int CTR_W_DFLT        = 24;
  localparam int PRESCALE_W_DFLT   = 16;
  localparam int PRESCALE_LIM_DFLT = 1000;

  localparam logic [2:0] OP_NOP            = 3'd0;
  localparam logic [2:0] OP_SET_PRESCALE   = 3'd1;
  localparam logic [2:0] OP_SET_COMPARE    = 3'd2;
  localparam logic [2:0] OP_START_ONESHOT  = 3'd3;
  localparam logic [2:0] OP_START_PERIODIC = 3'd4;
  localparam logic [2:0] OP_PAUSE          = 3'd5;
  localparam logic [2:0] OP_RESUME         = 3'd6;
  localparam logic [2:0] OP_STOP           = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// rtl/counter_sequencer_if.sv - command valid/ready channel into the counter sequencer
interface counter_sequencer_if #(
  parameter int CTR_W = counter_seq_pkg::CTR_W_DFLT
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CTR_W-1:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - run-gated prescaler producing a tick every lim+1 counting cycles
module counter_prescaler #(
  parameter int PRESCALE_W = counter_seq_pkg::PRESCALE_W_DFLT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] lim,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] count;

  // >= rather than == so a limit lowered below the running count ticks at once
  assign tick = run && (count >= lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (run) begin
      count <= count + PRESCALE_W'(1);
    end
  end
endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - command-driven run/pause/stop controller with compare for the demo counter
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int CTR_W            = CTR_W_DFLT,
  parameter int PRESCALE_W       = PRESCALE_W_DFLT,
  parameter int PRESCALE_DEFAULT = PRESCALE_LIM_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  counter_sequencer_if.slave  cmd,
  input  logic [CTR_W-1:0]    ctr_q,
  output logic                ctr_inc,
  output logic                ctr_clr,
  output logic                match_pulse,
  output logic [1:0]          state_o,
  output logic                busy
);
  state_t                state_q, state_d;
  mode_t                 mode_q, mode_d;
  logic [PRESCALE_W-1:0] lim_q;
  logic [CTR_W-1:0]      compare_q;
  logic                  inc_d, clr_d, match_d, ready_d, pre_clear;
  logic                  accept, halt, run, tick;
  logic [CTR_W-1:0]      cur_val, next_val;

  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  // A command that leaves RUN swallows a tick landing in the same cycle
  assign halt   = accept && (cmd.cmd_op inside {OP_START_ONESHOT, OP_START_PERIODIC,
                                                OP_PAUSE, OP_STOP});
  assign run    = (state_q == ST_RUN) && !halt;

  // ctr_q lags the strobes by one cycle, so fold in whatever is still in flight
  assign cur_val  = ctr_clr ? '0 : ctr_q + CTR_W'(ctr_inc);
  assign next_val = cur_val + CTR_W'(1);

  counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (pre_clear),
    .lim   (lim_q),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    inc_d     = 1'b0;
    clr_d     = 1'b0;
    match_d   = 1'b0;
    ready_d   = 1'b1;
    pre_clear = 1'b0;
    if (tick) begin
      if (next_val == compare_q) begin
        match_d = 1'b1;
        if (mode_q == MODE_PERIODIC) begin
          clr_d = 1'b1;
        end else begin
          inc_d   = 1'b1;
          state_d = ST_DONE;
        end
      end else begin
        inc_d = 1'b1;
      end
    end
    if (accept) begin
      case (cmd.cmd_op)
        OP_START_ONESHOT, OP_START_PERIODIC: begin
          state_d   = ST_RUN;
          mode_d    = (cmd.cmd_op == OP_START_PERIODIC) ? MODE_PERIODIC : MODE_ONESHOT;
          clr_d     = 1'b1;
          ready_d   = 1'b0;
          pre_clear = 1'b1;
        end
        OP_PAUSE:  if (state_q == ST_RUN)    state_d = ST_PAUSED;
        OP_RESUME: if (state_q == ST_PAUSED) state_d = ST_RUN;
        OP_STOP: begin
          if (state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            clr_d     = 1'b1;
            pre_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_ONESHOT;
      lim_q         <= PRESCALE_W'(PRESCALE_DEFAULT);
      compare_q     <= '0;
      ctr_inc       <= 1'b0;
      ctr_clr       <= 1'b0;
      match_pulse   <= 1'b0;
      cmd.cmd_ready <= 1'b1;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      ctr_inc       <= inc_d;
      ctr_clr       <= clr_d;
      match_pulse   <= match_d;
      cmd.cmd_ready <= ready_d;
      if (accept && cmd.cmd_op == OP_SET_PRESCALE) lim_q     <= cmd.cmd_data[PRESCALE_W-1:0];
      if (accept && cmd.cmd_op == OP_SET_COMPARE)  compare_q <= cmd.cmd_data;
    end
  end

  assign state_o = state_q;
  assign busy    = (state_q == ST_RUN) || (state_q == ST_PAUSED);
endmodule
